// File: rtl/tl_error_responder.sv
// Default TileLink slave: absorbs every A request and answers with a denied D response.
// Data responses carry zero data flagged corrupt; response length follows the request size.
module tl_error_responder #(
  parameter int BEAT_BYTES = 8,
  parameter int MAX_LGSIZE = 12,
  parameter int SOURCE_W   = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    auto_in_a_valid,
  output logic                    auto_in_a_ready,
  input  logic [2:0]              auto_in_a_bits_opcode,
  input  logic [3:0]              auto_in_a_bits_size,
  input  logic [SOURCE_W-1:0]     auto_in_a_bits_source,
  output logic                    auto_in_d_valid,
  input  logic                    auto_in_d_ready,
  output logic [2:0]              auto_in_d_bits_opcode,
  output logic [1:0]              auto_in_d_bits_param,
  output logic [3:0]              auto_in_d_bits_size,
  output logic [SOURCE_W-1:0]     auto_in_d_bits_source,
  output logic                    auto_in_d_bits_sink,
  output logic                    auto_in_d_bits_denied,
  output logic [8*BEAT_BYTES-1:0] auto_in_d_bits_data,
  output logic                    auto_in_d_bits_corrupt
);

  localparam int LG_BEAT = $clog2(BEAT_BYTES);
  localparam int CNT_W   = MAX_LGSIZE - LG_BEAT + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, RESP} state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [2:0]          op_q;
  logic [3:0]          size_q;
  logic [SOURCE_W-1:0] src_q;
  logic                cap;
  logic                a_fire, d_fire;

  // Beats minus one for a transfer; oversized requests are clamped to MAX_LGSIZE.
  function automatic logic [CNT_W-1:0] beats_m1(input logic [3:0] sz);
    logic [3:0] lg;
    lg = (sz > 4'(MAX_LGSIZE)) ? 4'(MAX_LGSIZE) : sz;
    if (lg <= 4'(LG_BEAT)) return '0;
    return (CNT_W'(1) << (lg - 4'(LG_BEAT))) - CNT_W'(1);
  endfunction

  function automatic logic has_data_d(input logic [2:0] op);
    return (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
  endfunction

  assign auto_in_a_ready = reset && (state != RESP);
  assign auto_in_d_valid = (state == RESP);
  assign a_fire          = auto_in_a_valid && auto_in_a_ready;
  assign d_fire          = auto_in_d_valid && auto_in_d_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cap      = 1'b0;
    case (state)
      IDLE: begin
        if (a_fire) begin
          cap = 1'b1;
          // Put/Arith/Logical carry one A beat per data beat.
          if (!auto_in_a_bits_opcode[2] && (beats_m1(auto_in_a_bits_size) != '0)) begin
            cnt_nx   = beats_m1(auto_in_a_bits_size) - CNT_W'(1);
            state_nx = DRAIN;
          end else begin
            cnt_nx   = has_data_d(auto_in_a_bits_opcode) ? beats_m1(auto_in_a_bits_size) : '0;
            state_nx = RESP;
          end
        end
      end
      DRAIN: begin
        if (a_fire) begin
          if (cnt == '0) begin
            cnt_nx   = has_data_d(op_q) ? beats_m1(size_q) : '0;
            state_nx = RESP;
          end else begin
            cnt_nx = cnt - CNT_W'(1);
          end
        end
      end
      RESP: begin
        if (d_fire) begin
          if (cnt == '0) state_nx = IDLE;
          else           cnt_nx   = cnt - CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      size_q <= '0;
      src_q  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (cap) begin
        op_q   <= auto_in_a_bits_opcode;
        size_q <= auto_in_a_bits_size;
        src_q  <= auto_in_a_bits_source;
      end
    end
  end

  always_comb begin
    if (has_data_d(op_q))    auto_in_d_bits_opcode = 3'd1;
    else if (op_q == 3'd5)   auto_in_d_bits_opcode = 3'd2;
    else                     auto_in_d_bits_opcode = 3'd0;
  end

  assign auto_in_d_bits_param   = 2'd0;
  assign auto_in_d_bits_size    = size_q;
  assign auto_in_d_bits_source  = src_q;
  assign auto_in_d_bits_sink    = 1'b0;
  assign auto_in_d_bits_denied  = 1'b1;
  assign auto_in_d_bits_data    = '0;
  assign auto_in_d_bits_corrupt = has_data_d(op_q);

endmodule

// File: tb/tb_tl_error_responder.sv
// Directed and randomized check of tl_error_responder against a transaction-level model.
module tb_tl_error_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_op = '0;
  logic [3:0]  a_size = '0;
  logic [4:0]  a_src = '0;
  logic        d_valid;
  logic        d_ready = 1'b1;
  logic [2:0]  d_op;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic [4:0]  d_src;
  logic        d_sink;
  logic        d_denied;
  logic [63:0] d_data;
  logic        d_corrupt;

  int n_checks = 0;
  int n_fails  = 0;

  tl_error_responder dut (
    .clock                  (clock),
    .reset                  (reset),
    .auto_in_a_valid        (a_valid),
    .auto_in_a_ready        (a_ready),
    .auto_in_a_bits_opcode  (a_op),
    .auto_in_a_bits_size    (a_size),
    .auto_in_a_bits_source  (a_src),
    .auto_in_d_valid        (d_valid),
    .auto_in_d_ready        (d_ready),
    .auto_in_d_bits_opcode  (d_op),
    .auto_in_d_bits_param   (d_param),
    .auto_in_d_bits_size    (d_size),
    .auto_in_d_bits_source  (d_src),
    .auto_in_d_bits_sink    (d_sink),
    .auto_in_d_bits_denied  (d_denied),
    .auto_in_d_bits_data    (d_data),
    .auto_in_d_bits_corrupt (d_corrupt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: transfer length in beats of 8 bytes, size clamped at 2^12.
  function automatic int model_beats(input int sz);
    int lg;
    lg = (sz > 12) ? 12 : sz;
    return (lg <= 3) ? 1 : (2 ** (lg - 3));
  endfunction

  function automatic int model_a_beats(input int op, input int sz);
    return (op < 4) ? model_beats(sz) : 1;
  endfunction

  function automatic int model_d_op(input int op);
    int tbl [8] = '{0, 0, 1, 1, 1, 2, 0, 0};
    return tbl[op];
  endfunction

  function automatic int model_d_beats(input int op, input int sz);
    return (model_d_op(op) == 1) ? model_beats(sz) : 1;
  endfunction

  task automatic send_a(input int op, input int sz, input int src, input bit gaps);
    int n;
    n = model_a_beats(op, sz);
    for (int b = 0; b < n; b++) begin
      @(negedge clock);
      while (gaps && ($urandom_range(0, 2) == 0)) begin
        a_valid = 1'b0;
        @(negedge clock);
      end
      a_valid = 1'b1;
      a_op    = (b == 0) ? 3'(op)  : 3'($urandom);
      a_size  = (b == 0) ? 4'(sz)  : 4'($urandom);
      a_src   = (b == 0) ? 5'(src) : 5'($urandom);
      check("a_ready_beat", 64'(a_ready), 64'd1);
      check("d_quiet_in_a", 64'(d_valid), 64'd0);
      @(posedge clock);
    end
  endtask

  // mode 0: d_ready held 1, 1: random, 2: toggling. Garbage A requests are offered meanwhile.
  task automatic collect_d(input int op, input int sz, input int src, input int mode);
    int n_exp, got, cyc;
    n_exp = model_d_beats(op, sz);
    got = 0;
    cyc = 0;
    while (got < n_exp && cyc < 20000) begin
      @(negedge clock);
      cyc++;
      case (mode)
        1:       d_ready = 1'($urandom);
        2:       d_ready = (cyc % 2 == 1);
        default: d_ready = 1'b1;
      endcase
      a_valid = 1'($urandom);
      a_op    = 3'($urandom);
      a_size  = 4'($urandom);
      a_src   = 5'($urandom);
      check("d_valid", 64'(d_valid), 64'd1);
      check("a_ready_resp", 64'(a_ready), 64'd0);
      check("d_opcode", 64'(d_op), 64'(model_d_op(op)));
      check("d_size", 64'(d_size), 64'(sz));
      check("d_source", 64'(d_src), 64'(src));
      check("d_denied", 64'(d_denied), 64'd1);
      check("d_corrupt", 64'(d_corrupt), 64'(model_d_op(op) == 1));
      check("d_data", d_data, 64'd0);
      check("d_param_sink", {61'd0, d_param, d_sink}, 64'd0);
      if (d_valid && d_ready) got++;
      @(posedge clock);
    end
    check("d_beat_count", 64'(got), 64'(n_exp));
    @(negedge clock);
    a_valid = 1'b0;
    d_ready = 1'b1;
    check("d_done", 64'(d_valid), 64'd0);
    check("a_ready_after", 64'(a_ready), 64'd1);
  endtask

  task automatic txn(input int op, input int sz, input int src, input bit gaps, input int mode);
    send_a(op, sz, src, gaps);
    collect_d(op, sz, src, mode);
  endtask

  initial begin
    #1;
    check("rst_a_ready", 64'(a_ready), 64'd0);
    check("rst_d_valid", 64'(d_valid), 64'd0);
    check("rst_d_size", 64'(d_size), 64'd0);
    check("rst_d_source", 64'(d_src), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("idle_a_ready", 64'(a_ready), 64'd1);

    txn(4, 3, 7, 1'b0, 0);
    txn(4, 6, 3, 1'b0, 2);
    txn(0, 5, 12, 1'b1, 0);
    txn(5, 2, 31, 1'b0, 0);
    txn(6, 4, 9, 1'b0, 1);
    txn(7, 0, 0, 1'b0, 0);
    txn(2, 4, 17, 1'b1, 1);
    txn(3, 7, 5, 1'b0, 0);
    txn(1, 3, 2, 1'b0, 1);
    txn(4, 15, 20, 1'b0, 0);
    txn(4, 12, 21, 1'b0, 0);

    for (int i = 0; i < 30; i++)
      txn($urandom_range(0, 7), $urandom_range(0, 9), $urandom_range(0, 31), 1'($urandom), $urandom_range(0, 2));

    // Reset during an 8-beat Get response.
    send_a(4, 6, 9, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      a_valid = 1'b0;
      d_ready = 1'b1;
      @(posedge clock);
    end
    #2 reset = 1'b0;
    #1;
    check("midrst_d_valid", 64'(d_valid), 64'd0);
    check("midrst_a_ready", 64'(a_ready), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("post_rst_d_valid", 64'(d_valid), 64'd0);
      check("post_rst_a_ready", 64'(a_ready), 64'd1);
    end
    txn(4, 3, 1, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
